pipe_stage_seq_argmax: RTL

- Parametrised successor to the stage-2 stage sequencer.
- Runs a start-triggered step counter through NSTAGE programmable stages and drives a per-stage reconfig mode bit.
- Keeps a per-lane fp16 running argmax (score, position) during ARGMAX_STAGE.
- During THRESH_STAGE, emits a registered center-id and norm result per lane against an fp16 threshold.
- Sits between the normalisation datapath and the reconfigurable tile.

---
 rtl/pipe_stage_seq_argmax.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_seq_argmax.sv
// Stage sequencer with per-lane fp16 running argmax and threshold result stage.
// Latency: argmax update and threshold result both land 1 cycle after an accepted input.
// Backpressure: stall_i freezes the step counter and blocks input acceptance; start_i always wins in IDLE/DONE.
module pipe_stage_seq_argmax #(
    parameter int                WIDTH        = 16,
    parameter int                LANES        = 2,
    parameter int                NSTAGE       = 8,
    parameter int                STEP_W       = 16,
    parameter int                ID_W         = 16,
    parameter int                NULL_ID      = 4096,
    parameter int                ARGMAX_STAGE = 5,
    parameter int                THRESH_STAGE = 6,
    parameter logic [15:0]       THRESH       = 16'h3BD7,
    parameter logic [NSTAGE-1:0] MODE_MASK    = 8'hFD
) (
    input  logic                          CLK_i,
    input  logic                          RST_i,
    input  logic                          start_i,
    input  logic                          stall_i,
    input  logic [(NSTAGE-1)*STEP_W-1:0]  stage_boundary_i,
    input  logic                          in_valid_i,
    input  logic [LANES*WIDTH-1:0]        score_i,
    input  logic [LANES*ID_W-1:0]         pos_i,
    output logic [$clog2(NSTAGE)-1:0]     stage_o,
    output logic [STEP_W-1:0]             step_o,
    output logic                          busy_o,
    output logic                          finished_o,
    output logic                          mode_o,
    output logic [LANES*WIDTH-1:0]        max_score_o,
    output logic [LANES*ID_W-1:0]         max_id_o,
    output logic                          result_valid_o,
    output logic [LANES-1:0]              hit_o,
    output logic [LANES*ID_W-1:0]         center_id_o,
    output logic [LANES*WIDTH-1:0]        dnorm_o
);

    localparam int               SW         = $clog2(NSTAGE);
    localparam logic [SW-1:0]    LAST_STAGE = SW'(NSTAGE - 1);
    localparam logic [SW-1:0]    ARG_STAGE  = SW'(ARGMAX_STAGE);
    localparam logic [SW-1:0]    THR_STAGE  = SW'(THRESH_STAGE);
    localparam logic [WIDTH-1:0] NEG_INF    = 16'hFC00;
    localparam logic [WIDTH-1:0] ONE_FP     = 16'h3C00;
    localparam logic [ID_W-1:0]  NULL_V     = ID_W'(NULL_ID);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;
    logic   clr;
    logic   accept;
    logic   acc_arg;
    logic   acc_thr;

    // fp16 strict greater-than over the total order; NaN never wins, signed zeros tie
    function automatic logic fp_gt(input logic [15:0] a, input logic [15:0] b);
        logic        nan_a, nan_b, both_zero;
        logic [15:0] ka, kb;
        nan_a     = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        nan_b     = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        both_zero = (a[14:0] == 15'd0) && (b[14:0] == 15'd0);
        ka        = a[15] ? ~a : (a | 16'h8000);
        kb        = b[15] ? ~b : (b | 16'h8000);
        return !nan_a && !nan_b && !both_zero && (ka > kb);
    endfunction

    // Stage is the count of boundaries strictly below the current step
    always_comb begin
        stage_o = '0;
        for (int k = 0; k < NSTAGE - 1; k++) begin
            if (step_o > stage_boundary_i[k*STEP_W +: STEP_W]) begin
                stage_o = stage_o + SW'(1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: start launches a run, reaching the last stage ends it
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = RUN;
            RUN:     if (stage_o == LAST_STAGE) state_nxt = DONE;
            DONE:    if (start_i) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs and input-acceptance qualifiers
    always_comb begin
        busy_o     = (state == RUN);
        finished_o = (state == DONE);
        mode_o     = MODE_MASK[stage_o];
        clr        = start_i && (state != RUN);
        accept     = (state == RUN) && in_valid_i && !stall_i;
        acc_arg    = accept && (stage_o == ARG_STAGE);
        acc_thr    = accept && (stage_o == THR_STAGE);
    end

    // Step counter: saturating, held on stall and on the edge that enters DONE
    always_ff @(posedge CLK_i) begin
        if (RST_i || clr) begin
            step_o <= '0;
        end else if ((state == RUN) && !stall_i && (stage_o != LAST_STAGE) && (step_o != '1)) begin
            step_o <= step_o + STEP_W'(1);
        end
    end

    // Per-lane running argmax; strict compare keeps the earliest position on ties
    always_ff @(posedge CLK_i) begin
        if (RST_i || clr) begin
            for (int l = 0; l < LANES; l++) begin
                max_score_o[l*WIDTH +: WIDTH] <= NEG_INF;
                max_id_o[l*ID_W +: ID_W]      <= NULL_V;
            end
        end else if (acc_arg) begin
            for (int l = 0; l < LANES; l++) begin
                if (fp_gt(score_i[l*WIDTH +: WIDTH], max_score_o[l*WIDTH +: WIDTH])) begin
                    max_score_o[l*WIDTH +: WIDTH] <= score_i[l*WIDTH +: WIDTH];
                    max_id_o[l*ID_W +: ID_W]      <= pos_i[l*ID_W +: ID_W];
                end
            end
        end
    end

    // Threshold result: one-cycle valid pulse, data held until the next pulse
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            result_valid_o <= 1'b0;
            hit_o          <= '0;
            for (int l = 0; l < LANES; l++) begin
                center_id_o[l*ID_W +: ID_W] <= NULL_V;
                dnorm_o[l*WIDTH +: WIDTH]   <= ONE_FP;
            end
        end else begin
            result_valid_o <= acc_thr;
            if (acc_thr) begin
                for (int l = 0; l < LANES; l++) begin
                    if (fp_gt(score_i[l*WIDTH +: WIDTH], THRESH)) begin
                        hit_o[l]                    <= 1'b1;
                        center_id_o[l*ID_W +: ID_W] <= max_id_o[l*ID_W +: ID_W];
                        dnorm_o[l*WIDTH +: WIDTH]   <= score_i[l*WIDTH +: WIDTH];
                    end else begin
                        hit_o[l]                    <= 1'b0;
                        center_id_o[l*ID_W +: ID_W] <= NULL_V;
                        dnorm_o[l*WIDTH +: WIDTH]   <= ONE_FP;
                    end
                end
            end
        end
    end

endmodule
